// File: rtl/barrel_shifter_8bit.sv
// Registered 8-bit barrel shifter: SLL, SRL, SRA or ROL by 0-7 positions.
// The operand passes through a three-stage log shifter (1, 2, 4) and is registered once.
module barrel_shifter_8bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic [2:0] smt,
  input  logic [1:0] mode,
  output logic [7:0] data_out
);

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  // One log-shifter stage. Bit 7 survives every SRA stage, so each stage
  // replicates the original sign bit without needing it passed separately.
  function automatic logic [7:0] shift_stage(input logic [7:0]  v,
                                             input logic        en,
                                             input logic [1:0]  op,
                                             input int unsigned k);
    logic signed [7:0] sv;
    logic        [7:0] r;
    sv = $signed(v);
    r  = v;
    if (en) begin
      case (op)
        MODE_SLL: r = v << k;
        MODE_SRL: r = v >> k;
        MODE_SRA: r = $unsigned(sv >>> k);
        default:  r = (v << k) | (v >> (8 - k));
      endcase
    end
    return r;
  endfunction

  logic [7:0] stg1_p0;
  logic [7:0] stg2_p1;
  logic [7:0] stg4_p2;
  logic [7:0] data_out_d;
  logic [7:0] data_out_q;

  // stage p0: shift by 1
  assign stg1_p0 = shift_stage(data_in, smt[0], mode, 1);
  // stage p1: shift by 2
  assign stg2_p1 = shift_stage(stg1_p0, smt[1], mode, 2);
  // stage p2: shift by 4
  assign stg4_p2 = shift_stage(stg2_p1, smt[2], mode, 4);

  assign data_out_d = stg4_p2;

  // output register
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q <= 8'h00;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_barrel_shifter_8bit.sv
// Bench for barrel_shifter_8bit: directed literal cases plus a random regression
// compared every cycle against a whole-amount behavioural model.
module tb_barrel_shifter_8bit;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic [2:0] smt;
  logic [1:0] mode;
  logic [7:0] data_out;

  int checks;
  int failures;

  logic [7:0] exp_q;
  logic       exp_vld;

  barrel_shifter_8bit dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .smt      (smt),
    .mode     (mode),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Whole-amount reference: arithmetic on integers, rotation by bit index.
  function automatic logic [7:0] ref_model(input logic [7:0] d, input int s, input logic [1:0] m);
    int v;
    int sv;
    logic [7:0] r;
    v  = int'(d);
    sv = d[7] ? v - 256 : v;
    r  = 8'h00;
    case (m)
      2'b00: r = 8'((v * (1 << s)) % 256);
      2'b01: r = 8'(v / (1 << s));
      2'b10: r = 8'(sv >>> s);
      default: begin
        for (int i = 0; i < 8; i++) r[(i + s) % 8] = d[i];
      end
    endcase
    return r;
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%02h expected=%02h", nm, act, exp);
    end
  endtask

  // Expected result for whatever the DUT samples on each edge.
  always @(posedge clk) begin
    if (rst) exp_q = 8'h00;
    else     exp_q = ref_model(data_in, int'(smt), mode);
    exp_vld = 1'b1;
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (exp_vld) check("model", data_out, exp_q);
  end

  task automatic apply(input logic r, input logic [7:0] d, input logic [2:0] s,
                       input logic [1:0] m, input logic [7:0] lit, input string nm);
    @(negedge clk);
    rst = r; data_in = d; smt = s; mode = m;
    @(posedge clk);
    #1;
    check(nm, data_out, lit);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_vld  = 1'b0;
    exp_q    = 8'h00;
    rst = 1'b1; data_in = 8'h00; smt = 3'd0; mode = 2'b00;

    // Pin the model itself with hand-computed values.
    check("model_sll", ref_model(8'hAA, 3, 2'b00), 8'h50);
    check("model_srl", ref_model(8'hAA, 2, 2'b01), 8'h2A);
    check("model_sra", ref_model(8'hF0, 1, 2'b10), 8'hF8);
    check("model_rol", ref_model(8'hD5, 3, 2'b11), 8'hAE);
    check("model_sra7", ref_model(8'h80, 7, 2'b10), 8'hFF);

    apply(1'b1, 8'h5A, 3'd1, 2'b00, 8'h00, "reset_state");

    apply(1'b0, 8'b10101010, 3'd3, 2'b00, 8'b01010000, "sll_aa_3");
    apply(1'b0, 8'b10101010, 3'd2, 2'b01, 8'b00101010, "srl_aa_2");
    apply(1'b0, 8'b11110000, 3'd1, 2'b10, 8'b11111000, "sra_f0_1");
    apply(1'b0, 8'b11010101, 3'd3, 2'b11, 8'b10101110, "rol_d5_3");

    for (int m = 0; m < 4; m++) apply(1'b0, 8'hA5, 3'd0, 2'(m), 8'hA5, "smt0_a5");

    apply(1'b0, 8'h80, 3'd7, 2'b10, 8'hFF, "sra_80_7");
    apply(1'b0, 8'h80, 3'd7, 2'b01, 8'h01, "srl_80_7");
    apply(1'b0, 8'h80, 3'd7, 2'b00, 8'h00, "sll_80_7");
    apply(1'b0, 8'h80, 3'd7, 2'b11, 8'h40, "rol_80_7");
    apply(1'b0, 8'h01, 3'd7, 2'b00, 8'h80, "sll_01_7");
    apply(1'b0, 8'h70, 3'd4, 2'b10, 8'h07, "sra_pos_70_4");

    apply(1'b1, 8'hFF, 3'd0, 2'b00, 8'h00, "reset_mid");
    apply(1'b0, 8'hFF, 3'd0, 2'b00, 8'hFF, "after_reset");

    // Input changes between edges must not reach data_out.
    apply(1'b0, 8'h3C, 3'd2, 2'b00, 8'hF0, "latency_pre");
    #2;
    data_in = 8'hC3; smt = 3'd5; mode = 2'b11;
    #1;
    check("hold_between_edges", data_out, 8'hF0);
    @(posedge clk);
    #1;
    check("latency_post", data_out, 8'h78);

    // Back-to-back random regression, occasional reset.
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      rst     = ($urandom_range(0, 63) == 0);
      data_in = 8'($urandom);
      smt     = 3'($urandom);
      mode    = 2'($urandom);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
